// File: rtl/dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder
//
// Memory-side responder that stands in for the memory controller behind the
// data cache. It accepts word read/write requests and services them from an
// internal word-addressed store after LATENCY wait cycles. Completion is
// signalled with a one-cycle mem_ready pulse.
//
// Parameters:
//   LATENCY  wait cycles from acceptance to mem_ready (1..15)
//   ADDR_W   word-index width; store depth is 2**ADDR_W words
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   dREN / dWEN  read / write request, held by the requester until mem_ready
//   daddr        byte address; bits [ADDR_W+1:2] select the word
//   dstore       write data
//   dload        read data, valid in the mem_ready cycle, held otherwise
//   mem_ready    one-cycle completion pulse
//   busy         high while a request is in flight (WAIT and DONE)
//   req_err      sticky flag: dREN and dWEN were seen high together
//
// Optional build macro DCACHE_RESP_STATS_EN adds wrapping activity counters:
//   rd_count (32), wr_count (32), abort_count (16).
// ---------------------------------------------------------------------------
module dcache_mem_responder #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        mem_ready,
   output logic        busy,
   output logic        req_err
`ifdef DCACHE_RESP_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [15:0] abort_count
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [31:0]       data_q, data_d;
   logic              wr_op_q, wr_op_d;
   logic [31:0]       dload_q, dload_d;
   logic              mem_ready_q, mem_ready_d;
   logic              busy_q, busy_d;
   logic              req_err_q, req_err_d;

   logic [31:0]       mem [0:2**ADDR_W-1];
   logic [31:0]       rd_data_q;
   logic [ADDR_W-1:0] req_idx;
   logic [ADDR_W-1:0] rd_idx;
   logic              mem_we;

   // Byte offset and bits above the store depth are deliberately dropped,
   // which makes addresses wrap modulo the store size.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{daddr[31:ADDR_W+2], daddr[1:0]};

   assign req_idx = daddr[ADDR_W+1:2];

   // The read port follows the incoming address while idle so the word is
   // already registered by the end of the first WAIT cycle; this keeps
   // LATENCY=1 working with a registered-read store.
   assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
   assign mem_we = (state_q == DONE) && wr_op_q;

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[idx_q] <= data_q;
      end
      rd_data_q <= mem[rd_idx];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      data_d      = data_q;
      wr_op_d     = wr_op_q;
      dload_d     = dload_q;
      mem_ready_d = 1'b0;
      busy_d      = busy_q;
      req_err_d   = req_err_q;
      case (state_q)
         IDLE: begin
            if (dREN || dWEN) begin
               state_d   = WAIT;
               cnt_d     = CNT_INIT;
               idx_d     = req_idx;
               data_d    = dstore;
               // A simultaneous read+write request is serviced as a write.
               wr_op_d   = dWEN;
               busy_d    = 1'b1;
               req_err_d = req_err_q | (dREN & dWEN);
            end
         end
         WAIT: begin
            if (!dREN && !dWEN) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q == 4'd0) begin
               state_d     = DONE;
               mem_ready_d = 1'b1;
               if (!wr_op_q) begin
                  dload_d = rd_data_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         data_q      <= 32'd0;
         wr_op_q     <= 1'b0;
         dload_q     <= 32'd0;
         mem_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         req_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         wr_op_q     <= wr_op_d;
         dload_q     <= dload_d;
         mem_ready_q <= mem_ready_d;
         busy_q      <= busy_d;
         req_err_q   <= req_err_d;
      end
   end

   assign dload     = dload_q;
   assign mem_ready = mem_ready_q;
   assign busy      = busy_q;
   assign req_err   = req_err_q;

`ifdef DCACHE_RESP_STATS_EN
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;
   logic [15:0] abort_count_q, abort_count_d;

   always_comb begin
      rd_count_d    = rd_count_q;
      wr_count_d    = wr_count_q;
      abort_count_d = abort_count_q;
      if (state_q == DONE) begin
         if (wr_op_q) begin
            wr_count_d = wr_count_q + 32'd1;
         end else begin
            rd_count_d = rd_count_q + 32'd1;
         end
      end
      if ((state_q == WAIT) && !dREN && !dWEN) begin
         abort_count_d = abort_count_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_count_q    <= 32'd0;
         wr_count_q    <= 32'd0;
         abort_count_q <= 16'd0;
      end else begin
         rd_count_q    <= rd_count_d;
         wr_count_q    <= wr_count_d;
         abort_count_q <= abort_count_d;
      end
   end

   assign rd_count    = rd_count_q;
   assign wr_count    = wr_count_q;
   assign abort_count = abort_count_q;
`endif

endmodule
